// File: rtl/iob_cache_ctrl_arb.sv
`default_nettype none
// ==== iob_cache_ctrl_arb: round-robin arbiter of two requesters onto the cache control port | rev 1.0 ====
module iob_cache_ctrl_arb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int INV_ADDR = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                r0_valid_i,
  input  logic [ADDR_W-1:0]   r0_addr_i,
  input  logic [DATA_W/8-1:0] r0_wstrb_i,
  output logic [DATA_W-1:0]   r0_rdata_o,
  output logic                r0_ready_o,
  output logic                r0_err_o,
  input  logic                r1_valid_i,
  input  logic [ADDR_W-1:0]   r1_addr_i,
  input  logic [DATA_W/8-1:0] r1_wstrb_i,
  output logic [DATA_W-1:0]   r1_rdata_o,
  output logic                r1_ready_o,
  output logic                r1_err_o,
  output logic                ctrl_valid_o,
  output logic [ADDR_W-1:0]   ctrl_addr_o,
  output logic [DATA_W/8-1:0] ctrl_wstrb_o,
  input  logic [DATA_W-1:0]   ctrl_rdata_i,
  input  logic                ctrl_ready_i,
  input  logic                wtbuf_empty_i,
  output logic                busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [ADDR_W-1:0] C_INV_ADDR = ADDR_W'(INV_ADDR);
  localparam logic [7:0]        C_TIMEOUT  = 8'(TIMEOUT);

  logic [2:0]          r_state;
  logic                r_owner;
  logic                r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [7:0]          r_cnt;

  logic                w_any;
  logic                w_gnt;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W/8-1:0] w_sel_wstrb;
  logic                w_drain;
  logic [7:0]          w_cnt_nxt;
  logic                w_resp;

  // With both requesting, the one that did not complete last wins.
  assign w_any       = r0_valid_i | r1_valid_i;
  assign w_gnt       = (r0_valid_i & r1_valid_i) ? ~r_last : r1_valid_i;
  assign w_sel_addr  = w_gnt ? r1_addr_i  : r0_addr_i;
  assign w_sel_wstrb = w_gnt ? r1_wstrb_i : r0_wstrb_i;
  assign w_drain     = (|w_sel_wstrb) && (w_sel_addr == C_INV_ADDR) && !wtbuf_empty_i;
  assign w_cnt_nxt   = r_cnt + 8'd1;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
    end else if (cke_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_gnt;
            r_addr  <= w_sel_addr;
            r_wstrb <= w_sel_wstrb;
            r_state <= w_drain ? S_DRAIN : S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (wtbuf_empty_i) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_cnt <= 8'd0;
          if (ctrl_ready_i) begin
            r_rdata <= ctrl_rdata_i;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          // A response arriving on the timeout cycle still counts as good data.
          if (ctrl_ready_i) begin
            r_rdata <= ctrl_rdata_i;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_cnt_nxt == C_TIMEOUT) begin
            r_rdata <= '1;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_resp       = (r_state == S_RESP);
  assign busy_o       = (r_state != S_IDLE);
  assign ctrl_valid_o = (r_state == S_ISSUE);
  assign ctrl_addr_o  = r_addr;
  assign ctrl_wstrb_o = r_wstrb;

  assign r0_ready_o = w_resp & ~r_owner;
  assign r1_ready_o = w_resp &  r_owner;
  assign r0_err_o   = r0_ready_o & r_err;
  assign r1_err_o   = r1_ready_o & r_err;
  assign r0_rdata_o = r0_ready_o ? r_rdata : '0;
  assign r1_rdata_o = r1_ready_o ? r_rdata : '0;

endmodule
`default_nettype wire
